// File: rtl/kamacore_stage_decode.sv
// Instruction decode stage: opcode decode, register file read with writeback bypass,
// load-use hazard detection and the ID/EX pipeline register.
module kamacore_stage_decode #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic [3:0]        ex_op_o,
    output logic [3:0]        ex_rd_o,
    output logic [DATA_W-1:0] ex_rs1_val_o,
    output logic [DATA_W-1:0] ex_rs2_val_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [ADDR_W-1:0] ex_pc_o,
    output logic              illegal_o
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned REG_AW = 4;
    localparam int unsigned IMM_W  = 16;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_ADDI  = 4'd3,
        OP_LOAD  = 4'd4,
        OP_STORE = 4'd5,
        OP_BEQ   = 4'd6,
        OP_JMP   = 4'd7
    } op_e;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs1_val;
        logic [DATA_W-1:0] rs2_val;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] pc;
        logic              illegal;
    } idex_t;

    // Instruction field extraction
    logic [OP_W-1:0]   op_raw;
    logic [REG_AW-1:0] rd_f;
    logic [REG_AW-1:0] rs1_f;
    logic [REG_AW-1:0] rs2_f;
    logic [IMM_W-1:0]  imm_f;

    assign op_raw = instr_i[DATA_W-1 -: OP_W];
    assign rd_f   = instr_i[DATA_W-OP_W-1 -: REG_AW];
    assign rs1_f  = instr_i[DATA_W-OP_W-REG_AW-1 -: REG_AW];
    assign rs2_f  = instr_i[DATA_W-OP_W-2*REG_AW-1 -: REG_AW];
    assign imm_f  = instr_i[IMM_W-1:0];

    // Opcode decode; opcodes with the top bit set are illegal and issue as NOP
    logic            legal;
    logic [OP_W-1:0] op_dec;
    logic            writes_rd;
    logic            rs1_used;
    logic            rs2_used;

    assign legal  = ~op_raw[OP_W-1];
    assign op_dec = legal ? op_raw : OP_W'(OP_NOP);

    always_comb begin
        writes_rd = 1'b0;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        case (op_e'(op_dec))
            OP_ADD, OP_SUB: begin
                writes_rd = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
            end
            OP_ADDI, OP_LOAD: begin
                writes_rd = 1'b1;
                rs1_used  = 1'b1;
            end
            OP_STORE, OP_BEQ: begin
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
            end
            default: begin
                writes_rd = 1'b0;
            end
        endcase
    end

    // Register file; not reset, r0 is never written
    logic [DATA_W-1:0] rf [NREGS];

    always_ff @(posedge clk) begin
        if (wb_we_i && (wb_rd_i != '0)) begin
            rf[wb_rd_i] <= wb_data_i;
        end
    end

    // Read with same-cycle writeback bypass so decode sees the value being retired
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1_f != '0) begin
            rs1_val = (wb_we_i && (wb_rd_i == rs1_f)) ? wb_data_i : rf[rs1_f];
        end
        if (rs2_f != '0) begin
            rs2_val = (wb_we_i && (wb_rd_i == rs2_f)) ? wb_data_i : rf[rs2_f];
        end
    end

    // Load-use hazard against the instruction currently in ID/EX
    idex_t idex_q;
    logic  hazard_src;

    assign hazard_src = (rs1_used && (rs1_f == idex_q.rd))
                      || (rs2_used && (rs2_f == idex_q.rd));
    assign stall_o    = valid_i && !flush_i && idex_q.valid
                      && (idex_q.op == OP_W'(OP_LOAD)) && (idex_q.rd != '0) && hazard_src;

    // Next ID/EX contents; flush, stall and invalid input all insert a bubble
    idex_t idex_d;

    always_comb begin
        idex_d = '0;
        if (valid_i && !flush_i && !stall_o) begin
            idex_d.valid   = 1'b1;
            idex_d.op      = op_dec;
            idex_d.rd      = writes_rd ? rd_f : '0;
            idex_d.rs1_val = rs1_val;
            idex_d.rs2_val = rs2_val;
            idex_d.imm     = {{(DATA_W-IMM_W){imm_f[IMM_W-1]}}, imm_f};
            idex_d.pc      = pc_i;
            idex_d.illegal = ~legal;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign ex_valid_o   = idex_q.valid;
    assign ex_op_o      = idex_q.op;
    assign ex_rd_o      = idex_q.rd;
    assign ex_rs1_val_o = idex_q.rs1_val;
    assign ex_rs2_val_o = idex_q.rs2_val;
    assign ex_imm_o     = idex_q.imm;
    assign ex_pc_o      = idex_q.pc;
    assign illegal_o    = idex_q.illegal;

endmodule

// File: tb/tb_kamacore_stage_decode.sv
// Bench for kamacore_stage_decode: hand-derived expectations queued per driven cycle.
module tb_kamacore_stage_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] pc;
    logic        flush;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [3:0]  ex_rd;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ill;
        bit          chk_ops;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    kamacore_stage_decode dut (
        .clk          (clk),
        .rst          (rst),
        .instr_i      (instr),
        .valid_i      (valid),
        .pc_i         (pc),
        .flush_i      (flush),
        .wb_we_i      (wb_we),
        .wb_rd_i      (wb_rd),
        .wb_data_i    (wb_data),
        .stall_o      (stall),
        .ex_valid_o   (ex_valid),
        .ex_op_o      (ex_op),
        .ex_rd_o      (ex_rd),
        .ex_rs1_val_o (ex_rs1_val),
        .ex_rs2_val_o (ex_rs2_val),
        .ex_imm_o     (ex_imm),
        .ex_pc_o      (ex_pc),
        .illegal_o    (illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t bub();
        exp_t e;
        e = '{v: 1'b0, op: 4'd0, rd: 4'd0, a: 32'd0, b: 32'd0, imm: 32'd0,
              pc: 32'd0, ill: 1'b0, chk_ops: 1'b1};
        return e;
    endfunction

    function automatic exp_t ins(input logic [3:0] op, input logic [3:0] rd,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [31:0] p);
        exp_t e;
        e = '{v: 1'b1, op: op, rd: rd, a: a, b: b, imm: imm, pc: p, ill: 1'b0, chk_ops: 1'b1};
        return e;
    endfunction

    function automatic exp_t ill_nop(input logic [31:0] p);
        exp_t e;
        e = '{v: 1'b1, op: 4'd0, rd: 4'd0, a: 32'd0, b: 32'd0, imm: 32'd0,
              pc: p, ill: 1'b1, chk_ops: 1'b0};
        return e;
    endfunction

    // Drive one cycle of inputs, check the combinational stall, then compare ID/EX after the edge
    task automatic step(input string tag, input logic [31:0] i, input logic v, input logic [31:0] p,
                        input logic f, input logic we, input logic [3:0] wrd, input logic [31:0] wd,
                        input logic exp_stall, input exp_t e);
        exp_t got;
        instr = i; valid = v; pc = p; flush = f;
        wb_we = we; wb_rd = wrd; wb_data = wd;
        #1;
        check({tag, ".stall"}, 32'(stall), 32'(exp_stall));
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({tag, ".valid"}, 32'(ex_valid), 32'(got.v));
        check({tag, ".op"},    32'(ex_op),    32'(got.op));
        check({tag, ".rd"},    32'(ex_rd),    32'(got.rd));
        check({tag, ".pc"},    ex_pc,         got.pc);
        check({tag, ".ill"},   32'(illegal),  32'(got.ill));
        if (got.chk_ops) begin
            check({tag, ".rs1"}, ex_rs1_val, got.a);
            check({tag, ".rs2"}, ex_rs2_val, got.b);
            check({tag, ".imm"}, ex_imm,     got.imm);
        end
    endtask

    task automatic wb(input string tag, input logic [3:0] r, input logic [31:0] d);
        step(tag, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, r, d, 1'b0, bub());
    endtask

    initial begin
        rst = 1'b0; instr = 32'h1534_0000; valid = 1'b1; pc = 32'h10; flush = 1'b0;
        wb_we = 1'b0; wb_rd = 4'd0; wb_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 32'(ex_valid), 32'd0);
        check("rst.op",    32'(ex_op),    32'd0);
        check("rst.rd",    32'(ex_rd),    32'd0);
        check("rst.rs1",   ex_rs1_val,    32'd0);
        check("rst.imm",   ex_imm,        32'd0);
        check("rst.pc",    ex_pc,         32'd0);
        check("rst.ill",   32'(illegal),  32'd0);
        check("rst.stall", 32'(stall),    32'd0);
        rst = 1'b1;

        wb("wb_r3", 4'd3, 32'd5);
        wb("wb_r4", 4'd4, 32'd7);
        wb("wb_r1", 4'd1, 32'h40);
        wb("wb_r2", 4'd2, 32'h22);
        wb("wb_r0", 4'd0, 32'hdead_beef);

        step("add", 32'h1534_0000, 1'b1, 32'h100, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd1, 4'd5, 32'd5, 32'd7, 32'd0, 32'h100));
        step("bypass", 32'h1533_0000, 1'b1, 32'h104, 1'b0, 1'b1, 4'd3, 32'h1234, 1'b0,
             ins(4'd1, 4'd5, 32'h1234, 32'h1234, 32'd0, 32'h104));
        step("r0_rd", 32'h2400_0000, 1'b1, 32'h108, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd2, 4'd4, 32'd0, 32'd0, 32'd0, 32'h108));
        step("invalid", 32'h1534_0000, 1'b0, 32'h10c, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, bub());

        // Load-use on rs1: one stall, one bubble, then the dependent ADD
        step("ld1", 32'h4210_0000, 1'b1, 32'h200, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd4, 4'd2, 32'h40, 32'd0, 32'd0, 32'h200));
        step("lu_stall", 32'h1620_0000, 1'b1, 32'h204, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, bub());
        step("lu_add", 32'h1620_0000, 1'b1, 32'h204, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd1, 4'd6, 32'h22, 32'd0, 32'd0, 32'h204));

        // LOAD into r0 never creates a hazard
        step("ld_r0", 32'h4010_0000, 1'b1, 32'h208, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd4, 4'd0, 32'h40, 32'd0, 32'd0, 32'h208));
        step("ld_r0_use", 32'h1600_0000, 1'b1, 32'h20c, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd1, 4'd6, 32'd0, 32'd0, 32'd0, 32'h20c));

        // Load-use through rs2 of a STORE; STORE rd forced to 0
        step("ld2", 32'h4210_0000, 1'b1, 32'h210, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd4, 4'd2, 32'h40, 32'd0, 32'd0, 32'h210));
        step("st_stall", 32'h5702_0010, 1'b1, 32'h214, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, bub());
        step("st", 32'h5702_0010, 1'b1, 32'h214, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd5, 4'd0, 32'd0, 32'h22, 32'h10, 32'h214));

        // NOP after LOAD uses no operands: no stall, rd forced 0
        step("ld3", 32'h4210_0000, 1'b1, 32'h218, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd4, 4'd2, 32'h40, 32'd0, 32'd0, 32'h218));
        step("nop", 32'h0220_0000, 1'b1, 32'h21c, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd0, 4'd0, 32'h22, 32'd0, 32'd0, 32'h21c));

        // Flush beats the hazard
        step("ld4", 32'h4210_0000, 1'b1, 32'h220, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd4, 4'd2, 32'h40, 32'd0, 32'd0, 32'h220));
        step("flush", 32'h1620_0000, 1'b1, 32'h224, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, bub());

        step("addi", 32'h3100_fffe, 1'b1, 32'h300, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd3, 4'd1, 32'd0, 32'd0, 32'hffff_fffe, 32'h300));
        step("addi_pos", 32'h3134_7fff, 1'b1, 32'h304, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd3, 4'd1, 32'h1234, 32'd7, 32'h0000_7fff, 32'h304));
        step("jmp", 32'h7500_8000, 1'b1, 32'h308, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd7, 4'd0, 32'd0, 32'd0, 32'hffff_8000, 32'h308));

        step("illegal", 32'ha500_0000, 1'b1, 32'h400, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, ill_nop(32'h400));
        step("ill_after", 32'h0, 1'b0, 32'h404, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, bub());
        step("ill_flush", 32'ha500_0000, 1'b1, 32'h408, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, bub());
        step("ill_f", 32'hf000_0000, 1'b1, 32'h40c, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, ill_nop(32'h40c));

        // Reset mid-stream clears an in-flight instruction
        step("pre_rst", 32'h4210_0000, 1'b1, 32'h500, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd4, 4'd2, 32'h40, 32'd0, 32'd0, 32'h500));
        rst = 1'b0;
        step("rst_mid", 32'h1620_0000, 1'b1, 32'h504, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, bub());
        rst = 1'b1;
        step("post_rst", 32'h1620_0000, 1'b1, 32'h504, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
             ins(4'd1, 4'd6, 32'h22, 32'd0, 32'd0, 32'h504));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
